instruction_fetch: RTL and testbench
====================================

INSTRUCTION_FETCH -- requirements
Module: Instruction_Fetch

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, the instruction buffer depth in entries (power of two, at least 2).
REQ-002 The block SHALL have parameter RESET_PC, default 8'h00, the PC loaded after reset.
REQ-003 The block SHALL have port clock, input, 1, the single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 The block SHALL have port PC_OUT, input, 8, the current PC from the program counter.
REQ-006 The block SHALL have port SET_PC, output, 1, a load strobe to the program counter.
REQ-007 The block SHALL have port PC_IN, output, 8, the load value to the program counter.
REQ-008 The block SHALL have port INC_PC, output, 1, the PC+4 strobe to the program counter.
REQ-009 The block SHALL have port BRANCH_VALID, input, 1, a redirect request, single-cycle.
REQ-010 The block SHALL have port BRANCH_TARGET, input, 8, the redirect address.
REQ-011 The block SHALL have ports MEM_REQ (output, 1) and MEM_ADDR (output, 8), the instruction memory read request and its address.
REQ-012 The block SHALL have ports MEM_ACK (input, 1) and MEM_RDATA (input, 32), the read completion and its data, valid with MEM_ACK.
REQ-013 The block SHALL have ports INSTR_VALID (output, 1), INSTR (output, 32) and INSTR_PC (output, 8), the head buffer entry.
REQ-014 The block SHALL have port INSTR_READY, input, 1, the decoder's acceptance of the head entry.

Function
REQ-015 The block SHALL implement states BOOT, IDLE, REQ and DRAIN.
REQ-016 In BOOT, the block SHALL drive SET_PC=1 and PC_IN=RESET_PC for exactly one cycle, then go to IDLE.
REQ-017 In IDLE, with count < DEPTH and BRANCH_VALID=0, the block SHALL go to REQ and register MEM_ADDR=PC_OUT.
REQ-018 In REQ, MEM_REQ SHALL be 1 and MEM_ADDR SHALL stay stable until MEM_ACK.
REQ-019 On MEM_ACK in REQ with BRANCH_VALID=0, the block SHALL:
  - push {MEM_RDATA, MEM_ADDR} into the buffer;
  - drive INC_PC=1 combinationally in that same cycle;
  - go to IDLE.
REQ-020 The fetch loop SHALL sustain at most one outstanding request, i.e. a 2-cycle minimum per fetch.
REQ-021 On BRANCH_VALID=1 in any state other than BOOT, the block SHALL, in the same cycle:
  - drive SET_PC=1 and PC_IN=BRANCH_TARGET combinationally;
  - flush the buffer at the clock edge;
  - force INSTR_VALID=0;
  - suppress INC_PC.
REQ-022 On BRANCH_VALID in REQ without MEM_ACK, the block SHALL go to DRAIN.
REQ-023 In DRAIN, the block SHALL hold MEM_REQ=1 with the old MEM_ADDR until MEM_ACK, discard the returned data without INC_PC, then go to IDLE.
REQ-024 On BRANCH_VALID in REQ coincident with MEM_ACK, the block SHALL discard the data and go to IDLE.
REQ-025 On BRANCH_VALID in DRAIN, the block SHALL re-issue SET_PC and remain in DRAIN.
REQ-026 SET_PC and INC_PC SHALL never be asserted in the same cycle.
REQ-027 On BRANCH_VALID in BOOT, the block SHALL ignore the branch; BOOT's SET_PC takes priority.
REQ-028 The buffer SHALL be a FIFO with count 0..DEPTH.
REQ-029 INSTR_VALID SHALL equal (count != 0) AND NOT BRANCH_VALID.
REQ-030 The buffer SHALL pop when INSTR_VALID && INSTR_READY.
REQ-031 A simultaneous push and pop SHALL leave count unchanged and preserve order.
REQ-032 The pointers SHALL wrap modulo DEPTH.
REQ-033 The buffer SHALL never overflow, since a request issues only when count < DEPTH.
REQ-034 When the buffer is empty, INSTR and INSTR_PC SHALL be don't-care.
REQ-035 PC wrap (8'hFC+4 = 8'h00) SHALL be owned by the program counter; this block SHALL fetch at whatever PC_OUT presents.

Reset
REQ-036 While reset=1, the block SHALL hold state=BOOT, count=0 and pointers=0.
REQ-037 While reset=1, MEM_REQ, INC_PC, SET_PC and INSTR_VALID SHALL be 0, and MEM_ADDR and PC_IN SHALL be 8'h00.
REQ-038 Reset asserted mid-request SHALL abandon the request; the memory side SHALL tolerate a dropped MEM_REQ.
REQ-039 The first cycle after reset release SHALL be BOOT.

Verification
REQ-040 The bench SHALL cover boot fetch:
  - Stimulus: release reset; memory acks after 1 cycle with 32'hA0000001, 32'hA0000002; INSTR_READY=1.
  - Response: SET_PC pulse with PC_IN=8'h00; INSTR/INSTR_PC = A0000001/00 then A0000002/04; one INC_PC per ack.
REQ-041 The bench SHALL cover a full buffer:
  - Stimulus: INSTR_READY=0; memory acks immediately.
  - Response: exactly 4 fetches (PC 00,04,08,0C); MEM_REQ stays 0 while count=4; one pop reopens exactly one fetch at PC 10.
REQ-042 The bench SHALL cover a branch during a pending request:
  - Stimulus: BRANCH_VALID, BRANCH_TARGET=8'h40, while REQ at 8'h08 waits 3 cycles for MEM_ACK.
  - Response: SET_PC with PC_IN=40; buffer emptied; DRAIN holds MEM_ADDR=08; ack data dropped; next MEM_ADDR=40; no INC_PC.
REQ-043 The bench SHALL cover a branch coincident with MEM_ACK and a pop:
  - Response: no push; INSTR_VALID=0 that cycle; SET_PC=1 and INC_PC=0; count=0 next cycle.
REQ-044 The bench SHALL cover wrap:
  - Stimulus: branch to 8'hF8.
  - Response: fetches at F8, FC, 00 with INSTR_PC tags matching.
REQ-045 The bench SHALL cover reset mid-REQ:
  - Stimulus: assert reset asynchronously while MEM_REQ=1.
  - Response: MEM_REQ=0 and INSTR_VALID=0 immediately; after release, SET_PC with PC_IN=RESET_PC.
REQ-046 The bench SHALL check every cycle that SET_PC && INC_PC never occurs.

Source files
------------

// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module  : instruction_fetch
// Brief   : Single-outstanding instruction fetcher with a FIFO instruction
//           buffer, branch redirect/flush and PC load/increment strobes.
// Rev     : 1.0 - initial release
// ============================================================================
module instruction_fetch #(
    parameter int         DEPTH    = 4,
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  PC_OUT,
    output logic        SET_PC,
    output logic [7:0]  PC_IN,
    output logic        INC_PC,
    input  logic        BRANCH_VALID,
    input  logic [7:0]  BRANCH_TARGET,
    output logic        MEM_REQ,
    output logic [7:0]  MEM_ADDR,
    input  logic        MEM_ACK,
    input  logic [31:0] MEM_RDATA,
    output logic        INSTR_VALID,
    output logic [31:0] INSTR,
    output logic [7:0]  INSTR_PC,
    input  logic        INSTR_READY
);

    localparam int            PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int            CW      = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] c_depth = CW'(DEPTH);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        IDLE  = 2'd1,
        REQ   = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [7:0]     r_mem_addr;
    logic [PW-1:0]  r_wr_ptr;
    logic [PW-1:0]  r_rd_ptr;
    logic [CW-1:0]  r_count;
    logic [39:0]    r_buf [DEPTH];

    logic           w_issue;
    logic           w_push;
    logic           w_pop;
    logic           w_flush;
    logic           w_set_pc;
    logic [7:0]     w_pc_in;
    logic           w_inc_pc;
    logic           w_instr_valid;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= BOOT;
            r_mem_addr <= 8'h00;
        end else begin
            r_state <= w_state_nxt;
            if (w_issue) begin
                r_mem_addr <= PC_OUT;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_push      = 1'b0;
        w_flush     = 1'b0;
        w_set_pc    = 1'b0;
        w_pc_in     = 8'h00;
        w_inc_pc    = 1'b0;
        case (r_state)
            BOOT: begin
                // A branch here is ignored: the boot load owns the PC.
                w_set_pc    = 1'b1;
                w_pc_in     = RESET_PC;
                w_state_nxt = IDLE;
            end
            IDLE: begin
                if (BRANCH_VALID) begin
                    w_set_pc = 1'b1;
                    w_pc_in  = BRANCH_TARGET;
                    w_flush  = 1'b1;
                end else if (r_count < c_depth) begin
                    w_issue     = 1'b1;
                    w_state_nxt = REQ;
                end
            end
            REQ: begin
                if (BRANCH_VALID) begin
                    w_set_pc    = 1'b1;
                    w_pc_in     = BRANCH_TARGET;
                    w_flush     = 1'b1;
                    w_state_nxt = MEM_ACK ? IDLE : DRAIN;
                end else if (MEM_ACK) begin
                    w_push      = 1'b1;
                    w_inc_pc    = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            DRAIN: begin
                if (BRANCH_VALID) begin
                    w_set_pc = 1'b1;
                    w_pc_in  = BRANCH_TARGET;
                    w_flush  = 1'b1;
                end
                // The ack retires the stale request even if a new branch lands
                // on it; waiting on would hang since nothing is outstanding.
                if (MEM_ACK) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = BOOT;
        endcase
    end

    assign w_instr_valid = (r_count != '0) && !BRANCH_VALID;
    assign w_pop         = w_instr_valid && INSTR_READY;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (w_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Payload storage carries no reset; entries are only read when counted.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_buf[r_wr_ptr] <= {MEM_RDATA, r_mem_addr};
        end
    end

    // Strobes are gated by reset because BOOT is the reset state.
    assign SET_PC      = w_set_pc && !reset;
    assign PC_IN       = reset ? 8'h00 : w_pc_in;
    assign INC_PC      = w_inc_pc && !reset;
    assign MEM_REQ     = (r_state == REQ) || (r_state == DRAIN);
    assign MEM_ADDR    = r_mem_addr;
    assign INSTR_VALID = w_instr_valid;
    assign INSTR       = r_buf[r_rd_ptr][39:8];
    assign INSTR_PC    = r_buf[r_rd_ptr][7:0];

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module  : tb_instruction_fetch
// Brief   : Directed bench for instruction_fetch with a behavioural PC model.
// Rev     : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch;

    logic        clock;
    logic        reset;
    logic [7:0]  PC_OUT;
    logic        SET_PC;
    logic [7:0]  PC_IN;
    logic        INC_PC;
    logic        BRANCH_VALID;
    logic [7:0]  BRANCH_TARGET;
    logic        MEM_REQ;
    logic [7:0]  MEM_ADDR;
    logic        MEM_ACK;
    logic [31:0] MEM_RDATA;
    logic        INSTR_VALID;
    logic [31:0] INSTR;
    logic [7:0]  INSTR_PC;
    logic        INSTR_READY;

    int vectors;
    int miscompares;

    instruction_fetch #(.DEPTH(4), .RESET_PC(8'h00)) dut (
        .clock         (clock),
        .reset         (reset),
        .PC_OUT        (PC_OUT),
        .SET_PC        (SET_PC),
        .PC_IN         (PC_IN),
        .INC_PC        (INC_PC),
        .BRANCH_VALID  (BRANCH_VALID),
        .BRANCH_TARGET (BRANCH_TARGET),
        .MEM_REQ       (MEM_REQ),
        .MEM_ADDR      (MEM_ADDR),
        .MEM_ACK       (MEM_ACK),
        .MEM_RDATA     (MEM_RDATA),
        .INSTR_VALID   (INSTR_VALID),
        .INSTR         (INSTR),
        .INSTR_PC      (INSTR_PC),
        .INSTR_READY   (INSTR_READY)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Program counter the fetcher drives; 8-bit add wraps FC+4 to 00.
    always @(posedge clock or posedge reset) begin
        if (reset)       PC_OUT <= 8'hEE;
        else if (SET_PC) PC_OUT <= PC_IN;
        else if (INC_PC) PC_OUT <= PC_OUT + 8'd4;
    end

    always @(negedge clock) begin
        if (!reset) begin
            vectors++;
            assert (!(SET_PC && INC_PC)) else begin
                miscompares++;
                $error("FAIL set_inc_exclusive: observed SET_PC=%b INC_PC=%b expected not both", SET_PC, INC_PC);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Leaves the DUT in IDLE with PC_OUT = RESET_PC.
    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk1("boot_set_pc", SET_PC, 1'b1);
        chk8("boot_pc_in", PC_IN, 8'h00);
        tick();
    endtask

    // One immediate-ack fetch from IDLE: checks address and INC_PC, returns in IDLE.
    task automatic fetch_now(input logic [7:0] addr, input logic [31:0] data);
        tick();
        chk1("fetch_req", MEM_REQ, 1'b1);
        chk8("fetch_addr", MEM_ADDR, addr);
        MEM_ACK   = 1'b1;
        MEM_RDATA = data;
        #1;
        chk1("fetch_inc", INC_PC, 1'b1);
        tick();
        MEM_ACK = 1'b0;
        #1;
    endtask

    logic [7:0]  exp_pc   [4];
    logic [31:0] exp_data [4];

    initial begin
        vectors       = 0;
        miscompares   = 0;
        reset         = 1'b1;
        BRANCH_VALID  = 1'b0;
        BRANCH_TARGET = 8'h00;
        MEM_ACK       = 1'b0;
        MEM_RDATA     = 32'h0;
        INSTR_READY   = 1'b0;
        tick();
        tick();
        chk1("rst_set_pc", SET_PC, 1'b0);
        chk1("rst_inc_pc", INC_PC, 1'b0);
        chk1("rst_mem_req", MEM_REQ, 1'b0);
        chk1("rst_instr_valid", INSTR_VALID, 1'b0);
        chk8("rst_mem_addr", MEM_ADDR, 8'h00);
        chk8("rst_pc_in", PC_IN, 8'h00);

        // Boot fetch, memory acks one cycle late, decoder always ready
        INSTR_READY = 1'b1;
        reset = 1'b0;
        #1;
        chk1("boot_set_pc", SET_PC, 1'b1);
        chk8("boot_pc_in", PC_IN, 8'h00);
        tick();
        chk1("boot_one_cycle", SET_PC, 1'b0);
        chk1("idle_no_req", MEM_REQ, 1'b0);
        tick();
        chk1("req0", MEM_REQ, 1'b1);
        chk8("req0_addr", MEM_ADDR, 8'h00);
        chk1("req0_no_inc", INC_PC, 1'b0);
        tick();
        MEM_ACK = 1'b1; MEM_RDATA = 32'hA000_0001;
        #1;
        chk1("ack0_inc", INC_PC, 1'b1);
        tick();
        MEM_ACK = 1'b0;
        #1;
        chk1("head0_valid", INSTR_VALID, 1'b1);
        chk32("head0_instr", INSTR, 32'hA000_0001);
        chk8("head0_pc", INSTR_PC, 8'h00);
        tick();
        chk1("popped_empty", INSTR_VALID, 1'b0);
        chk8("req1_addr", MEM_ADDR, 8'h04);
        tick();
        MEM_ACK = 1'b1; MEM_RDATA = 32'hA000_0002;
        #1;
        chk1("ack1_inc", INC_PC, 1'b1);
        tick();
        MEM_ACK = 1'b0;
        #1;
        chk32("head1_instr", INSTR, 32'hA000_0002);
        chk8("head1_pc", INSTR_PC, 8'h04);

        // Full buffer: four fetches then stall until one pop
        INSTR_READY = 1'b0;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            fetch_now(8'(4 * i), 32'hB000_0000 + 32'(i));
        end
        chk32("full_head", INSTR, 32'hB000_0000);
        chk8("full_head_pc", INSTR_PC, 8'h00);
        tick();
        chk1("full_stall0", MEM_REQ, 1'b0);
        tick();
        chk1("full_stall1", MEM_REQ, 1'b0);
        INSTR_READY = 1'b1;
        #1;
        tick();
        INSTR_READY = 1'b0;
        #1;
        chk1("pop_same_cycle_idle", MEM_REQ, 1'b0);
        chk8("after_pop_head", INSTR_PC, 8'h04);
        fetch_now(8'h10, 32'hC000_0010);
        tick();
        chk1("refull_stall", MEM_REQ, 1'b0);
        exp_pc   = '{8'h04, 8'h08, 8'h0C, 8'h10};
        exp_data = '{32'hB000_0001, 32'hB000_0002, 32'hB000_0003, 32'hC000_0010};
        INSTR_READY = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk8("order_pc", INSTR_PC, exp_pc[i]);
            chk32("order_instr", INSTR, exp_data[i]);
            tick();
        end
        chk1("drained_empty", INSTR_VALID, 1'b0);
        INSTR_READY = 1'b0;

        // Branch while request at 08 is pending
        do_reset();
        fetch_now(8'h00, 32'hD000_0000);
        fetch_now(8'h04, 32'hD000_0004);
        tick();
        chk8("pend_addr", MEM_ADDR, 8'h08);
        chk1("pend_valid", INSTR_VALID, 1'b1);
        tick();
        BRANCH_VALID = 1'b1; BRANCH_TARGET = 8'h40;
        #1;
        chk1("br_set_pc", SET_PC, 1'b1);
        chk8("br_pc_in", PC_IN, 8'h40);
        chk1("br_valid_forced", INSTR_VALID, 1'b0);
        chk1("br_no_inc", INC_PC, 1'b0);
        tick();
        BRANCH_VALID = 1'b0;
        #1;
        chk1("drain_req", MEM_REQ, 1'b1);
        chk8("drain_addr", MEM_ADDR, 8'h08);
        chk1("drain_flushed", INSTR_VALID, 1'b0);
        tick();
        chk8("drain_addr_hold", MEM_ADDR, 8'h08);
        MEM_ACK = 1'b1; MEM_RDATA = 32'hDEAD_BEEF;
        #1;
        chk1("drain_ack_no_inc", INC_PC, 1'b0);
        tick();
        MEM_ACK = 1'b0;
        #1;
        chk1("drain_dropped", INSTR_VALID, 1'b0);
        tick();
        chk1("tgt_req", MEM_REQ, 1'b1);
        chk8("tgt_addr", MEM_ADDR, 8'h40);

        // Branch coincident with ack and pop
        MEM_ACK = 1'b1; MEM_RDATA = 32'hE000_0040;
        #1;
        tick();
        MEM_ACK = 1'b0;
        #1;
        tick();
        chk8("co_addr", MEM_ADDR, 8'h44);
        chk1("co_pre_valid", INSTR_VALID, 1'b1);
        chk8("co_pre_pc", INSTR_PC, 8'h40);
        MEM_ACK = 1'b1; MEM_RDATA = 32'hE000_0044;
        INSTR_READY = 1'b1; BRANCH_VALID = 1'b1; BRANCH_TARGET = 8'hF8;
        #1;
        chk1("co_valid_forced", INSTR_VALID, 1'b0);
        chk1("co_set_pc", SET_PC, 1'b1);
        chk1("co_no_inc", INC_PC, 1'b0);
        chk8("co_pc_in", PC_IN, 8'hF8);
        tick();
        MEM_ACK = 1'b0; INSTR_READY = 1'b0; BRANCH_VALID = 1'b0;
        #1;
        chk1("co_count0", INSTR_VALID, 1'b0);
        chk1("co_idle", MEM_REQ, 1'b0);

        // Wrap through FC -> 00
        fetch_now(8'hF8, 32'hF000_00F8);
        fetch_now(8'hFC, 32'hF000_00FC);
        fetch_now(8'h00, 32'hF000_0000);
        INSTR_READY = 1'b1;
        #1;
        chk8("wrap_pc0", INSTR_PC, 8'hF8);
        chk32("wrap_instr0", INSTR, 32'hF000_00F8);
        tick();
        chk8("wrap_pc1", INSTR_PC, 8'hFC);
        tick();
        INSTR_READY = 1'b0;
        #1;
        chk8("wrap_pc2", INSTR_PC, 8'h00);
        chk1("wrap_valid2", INSTR_VALID, 1'b1);
        chk1("wrap_next_req", MEM_REQ, 1'b1);
        chk8("wrap_next_addr", MEM_ADDR, 8'h04);

        // Asynchronous reset mid-request
        #2;
        reset = 1'b1;
        #1;
        chk1("arst_mem_req", MEM_REQ, 1'b0);
        chk1("arst_valid", INSTR_VALID, 1'b0);
        chk1("arst_set_pc", SET_PC, 1'b0);
        tick();
        reset = 1'b0;
        #1;
        chk1("arst_boot_set", SET_PC, 1'b1);
        chk8("arst_boot_pc", PC_IN, 8'h00);
        tick();
        chk1("arst_idle", MEM_REQ, 1'b0);
        tick();
        chk1("arst_refetch", MEM_REQ, 1'b1);
        chk8("arst_refetch_addr", MEM_ADDR, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
